green_classify_ctrl: RTL and testbench
======================================

Name: green_classify_ctrl

Overview:
- Sequential controller for the green-hand classification datapath.
- Replaces the all-pixels-at-once combinational filter/sum with a raster scan of a frame buffer, one pixel per accepted request.
- Per frame it applies the green threshold test, accumulates the total green count, the left-region green count and the leftmost green column, then runs a decision step.
- Emits a rock/paper/scissors/none result over a valid/ready handshake to the downstream consumer.

Parameters:
- LENGTH, 32: frame rows.
- WIDTH, 32: frame columns.
- LEFT, 8: columns 0..LEFT-1 form the left region; 1 <= LEFT <= WIDTH.
- MIN_PIXELS, 16: total green count below this gives class NONE.
- SCISSORS_MIN, 96: minimum total green count for SCISSORS.
- PAPER_MIN, 256: minimum total green count for PAPER; PAPER_MIN > SCISSORS_MIN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame start pulse; honoured only in IDLE
- busy  out  1  high in any state other than IDLE
- pix_req  out  1  pixel read request
- pix_row  out  $clog2(LENGTH)  requested row
- pix_col  out  $clog2(WIDTH)  requested column
- pix_valid  in  1  pixel data valid; may be high in the same cycle as pix_req
- pix_ch  in  3x8  channels 0, 1, 2, matching the image channel order
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result
- result_class  out  2  0 ROCK, 1 PAPER, 2 SCISSORS, 3 NONE
- sum  out  32  green pixel count for the frame
- sum_left  out  32  green pixel count in columns < LEFT
- leftmost_col  out  $clog2(WIDTH)  minimum column containing green; 0 if none
- leftmost_found  out  1  at least one green pixel in the frame

Behaviour:
- Reset: state IDLE. All outputs 0: busy, pix_req, pix_row, pix_col, result_valid, result_class, sum, sum_left, leftmost_col, leftmost_found.
- Reset mid-frame aborts the frame. A pending result is discarded. Any pix_valid arriving after reset is ignored.
- IDLE:
  - start=1 clears sum, sum_left, leftmost_col and leftmost_found.
  - Row and column counters go to 0; next state FETCH.
  - start is ignored in every other state.
- FETCH:
  - pix_req=1, with pix_row/pix_col equal to the current counters.
  - A pixel is accepted on an edge where pix_req and pix_valid are both high. At most one request is outstanding. Counters hold while pix_valid=0.
  - A pixel is green iff each channel lies in its inclusive [LOWER, UPPER] green threshold.
  - On a green accept:
    - sum += 1.
    - sum_left += 1 if col < LEFT.
    - If leftmost_found=0 or col < leftmost_col: leftmost_col <= col and leftmost_found <= 1.
  - Scan is raster order, column fastest. Column wraps WIDTH-1 -> 0 with row += 1.
  - The accept at (LENGTH-1, WIDTH-1) moves to DECIDE and drops pix_req on the next cycle.
- DECIDE (one cycle), evaluated in priority order:
  1. sum < MIN_PIXELS: NONE.
  2. sum >= PAPER_MIN: PAPER.
  3. sum >= SCISSORS_MIN and 2*sum_left < sum: SCISSORS.
  4. Otherwise: ROCK.
  - Comparisons are unsigned 32-bit; 2*sum_left is computed at 33 bits.
  - Registers result_class; next state DONE.
- DONE:
  - result_valid=1. result_class, sum, sum_left and leftmost_* are stable.
  - On result_ready=1: next state IDLE, result_valid drops.
  - A start in the same cycle is ignored; the next frame needs start in IDLE.
- Latency, with pix_valid tied high and start seen at edge 0:
  - Pixels are accepted at edges 1..N, where N = LENGTH*WIDTH.
  - result_valid is high after edge N+1.
- sum, sum_left and leftmost_* update live during FETCH. They are final only when result_valid=1.

Decomposition:
- Shared package holds:
  - LENGTH, WIDTH, LEFT defaults.
  - LOWER/UPPER_GREEN_ONE/TWO/THREE thresholds.
  - Result-class enum (ROCK, PAPER, SCISSORS, NONE).
  - State enum (IDLE, FETCH, DECIDE, DONE).
- One sub-module: green_pixel_test, a combinational three-channel in-range check returning 1 bit. It is reused by the existing whole-frame filter.

Test Plan (LENGTH=4, WIDTH=4, LEFT=2, MIN_PIXELS=2, SCISSORS_MIN=6, PAPER_MIN=12):
- All 16 pixels green, pix_valid tied high:
  - result_valid rises after edge 17.
  - sum=16, sum_left=8, leftmost_col=0, leftmost_found=1, class PAPER.
- Green only in columns 2-3 (8 pixels):
  - sum=8, sum_left=0, 2*0<8, class SCISSORS.
  - leftmost_col=2.
- Green only at (1,1), (3,3), (0,3):
  - sum=3, sum_left=1, leftmost_col=1, class ROCK.
- No green pixels:
  - sum=0, leftmost_found=0, leftmost_col=0, class NONE.
- pix_valid low for 3 cycles on every 4th request:
  - Identical results to the zero-wait run.
  - pix_row/pix_col hold while stalled.
- Reset and handshake edge cases:
  - rst high mid-FETCH after 5 accepts: all outputs 0 next cycle, state IDLE.
  - A fresh start then gives correct results.
  - start pulsed during FETCH or DONE: ignored.
  - result_ready held low for 10 cycles: result_valid and result_class stable throughout.

Source files
------------

// File: rtl/green_classify_ctrl_pkg.sv
// Shared types and constants for the green-hand classification controller.
// Holds frame-size defaults, green thresholds, result-class and FSM state enums.
package green_classify_ctrl_pkg;

    localparam int DEFAULT_LENGTH = 32;
    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_LEFT   = 8;

    // Inclusive green window per channel, in image channel order 0, 1, 2.
    localparam logic [7:0] LOWER_GREEN_ONE   = 8'h10;
    localparam logic [7:0] UPPER_GREEN_ONE   = 8'h60;
    localparam logic [7:0] LOWER_GREEN_TWO   = 8'h80;
    localparam logic [7:0] UPPER_GREEN_TWO   = 8'hF0;
    localparam logic [7:0] LOWER_GREEN_THREE = 8'h10;
    localparam logic [7:0] UPPER_GREEN_THREE = 8'h60;

    typedef logic [2:0][7:0] pixel_t;

    typedef enum logic [1:0] {
        CLS_ROCK     = 2'd0,
        CLS_PAPER    = 2'd1,
        CLS_SCISSORS = 2'd2,
        CLS_NONE     = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic in_range(
        input logic [7:0] v,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/green_classify_ctrl_if.sv
// Pixel-fetch and result handshake bundle for green_classify_ctrl.
// master: controller side (requests pixels, offers result); slave: frame buffer/consumer.
interface green_classify_ctrl_if
    import green_classify_ctrl_pkg::*;
#(
    parameter int LENGTH = DEFAULT_LENGTH,
    parameter int WIDTH  = DEFAULT_WIDTH
);
    localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic          pix_req;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;
    logic          pix_valid;
    pixel_t        pix_ch;

    logic          result_valid;
    logic          result_ready;
    logic [1:0]    result_class;
    logic [31:0]   sum;
    logic [31:0]   sum_left;
    logic [CW-1:0] leftmost_col;
    logic          leftmost_found;

    modport master (
        output pix_req, pix_row, pix_col,
        input  pix_valid, pix_ch,
        output result_valid, result_class, sum, sum_left,
        output leftmost_col, leftmost_found,
        input  result_ready
    );

    modport slave (
        input  pix_req, pix_row, pix_col,
        output pix_valid, pix_ch,
        input  result_valid, result_class, sum, sum_left,
        input  leftmost_col, leftmost_found,
        output result_ready
    );

endinterface

// File: rtl/green_classify_ctrl_green_pixel_test.sv
// Combinational green test: pixel is green when all three channels are in window.
// Ports: ch (3x8 channels 0..2) in, green out.
module green_pixel_test
    import green_classify_ctrl_pkg::*;
(
    input  pixel_t ch,
    output logic   green
);

    assign green = in_range(ch[0], LOWER_GREEN_ONE, UPPER_GREEN_ONE)
                && in_range(ch[1], LOWER_GREEN_TWO, UPPER_GREEN_TWO)
                && in_range(ch[2], LOWER_GREEN_THREE, UPPER_GREEN_THREE);

endmodule

// File: rtl/green_classify_ctrl.sv
// Raster-scan green-hand classifier: fetches one pixel per accept, counts green,
// then decides rock/paper/scissors/none. Ports: clk, rst, start, busy, bus (master).
module green_classify_ctrl
    import green_classify_ctrl_pkg::*;
#(
    parameter int LENGTH       = DEFAULT_LENGTH,
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int LEFT         = DEFAULT_LEFT,
    parameter int MIN_PIXELS   = 16,
    parameter int SCISSORS_MIN = 96,
    parameter int PAPER_MIN    = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    green_classify_ctrl_if.master bus
);

    localparam int RW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [RW-1:0] ROW_LAST = RW'(LENGTH - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [31:0]   LEFT_U   = 32'(LEFT);
    localparam logic [31:0]   MIN_U    = 32'(MIN_PIXELS);
    localparam logic [31:0]   SCIS_U   = 32'(SCISSORS_MIN);
    localparam logic [31:0]   PAPER_U  = 32'(PAPER_MIN);

    state_e        state_q;
    state_e        state_d;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [31:0]   sum_q;
    logic [31:0]   sum_left_q;
    logic [CW-1:0] lm_col_q;
    logic          lm_found_q;
    cls_e          cls_q;
    cls_e          cls_d;

    logic green;
    logic accept;
    logic last;
    logic in_left;
    logic new_left;

    green_pixel_test u_test (
        .ch    (bus.pix_ch),
        .green (green)
    );

    assign accept   = (state_q == ST_FETCH) && bus.pix_valid;
    assign last     = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // Widen the column so LEFT == WIDTH still compares correctly.
    assign in_left  = 32'(col_q) < LEFT_U;
    assign new_left = !lm_found_q || (col_q < lm_col_q);

    // 2*sum_left at 33 bits so the doubling cannot wrap.
    always_comb begin
        cls_d = CLS_ROCK;
        if (sum_q < MIN_U) begin
            cls_d = CLS_NONE;
        end else if (sum_q >= PAPER_U) begin
            cls_d = CLS_PAPER;
        end else if ((sum_q >= SCIS_U) &&
                     ({sum_left_q, 1'b0} < {1'b0, sum_q})) begin
            cls_d = CLS_SCISSORS;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  if (accept && last) state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_DONE;
            ST_DONE:   if (bus.result_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            sum_q      <= '0;
            sum_left_q <= '0;
            lm_col_q   <= '0;
            lm_found_q <= 1'b0;
            cls_q      <= CLS_ROCK;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && start) begin
                row_q      <= '0;
                col_q      <= '0;
                sum_q      <= '0;
                sum_left_q <= '0;
                lm_col_q   <= '0;
                lm_found_q <= 1'b0;
            end
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= last ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
                if (green) begin
                    sum_q <= sum_q + 32'd1;
                    if (in_left) sum_left_q <= sum_left_q + 32'd1;
                    if (new_left) begin
                        lm_col_q   <= col_q;
                        lm_found_q <= 1'b1;
                    end
                end
            end
            if (state_q == ST_DECIDE) cls_q <= cls_d;
        end
    end

    assign busy               = (state_q != ST_IDLE);
    assign bus.pix_req        = (state_q == ST_FETCH);
    assign bus.pix_row        = row_q;
    assign bus.pix_col        = col_q;
    assign bus.result_valid   = (state_q == ST_DONE);
    assign bus.result_class   = cls_q;
    assign bus.sum            = sum_q;
    assign bus.sum_left       = sum_left_q;
    assign bus.leftmost_col   = lm_col_q;
    assign bus.leftmost_found = lm_found_q;

endmodule

// File: tb/tb_green_classify_ctrl.sv
// Randomized self-checking bench for green_classify_ctrl on a 4x4 frame.
// Expected results come from a frame-level reference model.
module tb_green_classify_ctrl;
    import green_classify_ctrl_pkg::*;

    localparam int L    = 4;
    localparam int W    = 4;
    localparam int LF   = 2;
    localparam int MINP = 2;
    localparam int SCIM = 6;
    localparam int PAPM = 12;
    localparam int N    = L * W;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;

    green_classify_ctrl_if #(.LENGTH(L), .WIDTH(W)) bus ();

    pixel_t fb [L][W];

    int n_checks = 0;
    int n_errors = 0;

    int e_sum, e_left, e_lm, e_found, e_cls;

    always #5 clk = ~clk;

    assign bus.pix_ch = fb[bus.pix_row][bus.pix_col];

    green_classify_ctrl #(
        .LENGTH       (L),
        .WIDTH        (W),
        .LEFT         (LF),
        .MIN_PIXELS   (MINP),
        .SCISSORS_MIN (SCIM),
        .PAPER_MIN    (PAPM)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .bus   (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_green(input pixel_t p);
        int lo [3];
        int hi [3];
        lo[0] = int'(LOWER_GREEN_ONE);   hi[0] = int'(UPPER_GREEN_ONE);
        lo[1] = int'(LOWER_GREEN_TWO);   hi[1] = int'(UPPER_GREEN_TWO);
        lo[2] = int'(LOWER_GREEN_THREE); hi[2] = int'(UPPER_GREEN_THREE);
        for (int k = 0; k < 3; k++)
            if (int'(p[k]) < lo[k] || int'(p[k]) > hi[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic pixel_t mk_green();
        pixel_t p;
        logic [7:0] lo [3];
        logic [7:0] hi [3];
        lo[0] = LOWER_GREEN_ONE;   hi[0] = UPPER_GREEN_ONE;
        lo[1] = LOWER_GREEN_TWO;   hi[1] = UPPER_GREEN_TWO;
        lo[2] = LOWER_GREEN_THREE; hi[2] = UPPER_GREEN_THREE;
        for (int k = 0; k < 3; k++) begin
            case ($urandom_range(0, 2))
                0:       p[k] = lo[k];
                1:       p[k] = hi[k];
                default: p[k] = 8'($urandom_range(int'(lo[k]), int'(hi[k])));
            endcase
        end
        return p;
    endfunction

    // Green pixel with one channel pushed just outside its window.
    function automatic pixel_t mk_other();
        pixel_t p;
        int k;
        logic [7:0] lo [3];
        logic [7:0] hi [3];
        lo[0] = LOWER_GREEN_ONE;   hi[0] = UPPER_GREEN_ONE;
        lo[1] = LOWER_GREEN_TWO;   hi[1] = UPPER_GREEN_TWO;
        lo[2] = LOWER_GREEN_THREE; hi[2] = UPPER_GREEN_THREE;
        p = mk_green();
        k = $urandom_range(0, 2);
        case ($urandom_range(0, 2))
            0:       p[k] = lo[k] - 8'd1;
            1:       p[k] = hi[k] + 8'd1;
            default: p[k] = 8'($urandom_range(0, int'(lo[k]) - 1));
        endcase
        return p;
    endfunction

    task automatic fill(input int mode);
        int dens;
        dens = $urandom_range(0, 100);
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++) begin
                case (mode)
                    0: fb[r][c] = mk_green();
                    1: fb[r][c] = (c >= 2) ? mk_green() : mk_other();
                    2: fb[r][c] = ((r == 1 && c == 1) || (r == 3 && c == 3) ||
                                   (r == 0 && c == 3)) ? mk_green() : mk_other();
                    3: fb[r][c] = mk_other();
                    default: fb[r][c] = ($urandom_range(0, 99) < dens) ?
                                        mk_green() : mk_other();
                endcase
            end
    endtask

    task automatic model();
        e_sum = 0; e_left = 0; e_found = 0; e_lm = W;
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++)
                if (is_green(fb[r][c])) begin
                    e_sum++;
                    if (c < LF) e_left++;
                    if (c < e_lm) e_lm = c;
                    e_found = 1;
                end
        if (!e_found) e_lm = 0;
        if (e_sum < MINP) e_cls = 3;
        else if (e_sum >= PAPM) e_cls = 1;
        else if (e_sum >= SCIM && 2 * e_left < e_sum) e_cls = 2;
        else e_cls = 0;
    endtask

    task automatic run_frame(input bit stall, input bit poke, input int hold);
        int edges;
        int acc;
        int wc;
        model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        edges = 0; acc = 0; wc = 0;
        while (!bus.result_valid && edges < 200) begin
            start = 1'b0;
            if (bus.pix_req) begin
                check("pix_row", 32'(bus.pix_row), acc / W);
                check("pix_col", 32'(bus.pix_col), acc % W);
                if (stall && (acc % 4 == 3) && wc < 3) begin
                    bus.pix_valid = 1'b0;
                    wc++;
                end else begin
                    bus.pix_valid = 1'b1;
                    wc = 0;
                    acc++;
                end
                if (poke && $urandom_range(0, 3) == 0) start = 1'b1;
            end else begin
                bus.pix_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("result_valid_reached", 32'(bus.result_valid), 1);
        check("accepted_count", acc, N);
        if (!stall) check("latency_edges", edges, N + 1);
        check("sum", 32'(bus.sum), e_sum);
        check("sum_left", 32'(bus.sum_left), e_left);
        check("leftmost_col", 32'(bus.leftmost_col), e_lm);
        check("leftmost_found", 32'(bus.leftmost_found), e_found);
        check("result_class", 32'(bus.result_class), e_cls);
        for (int i = 0; i < hold; i++) begin
            bus.result_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            bus.pix_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.result_valid), 1);
            check("hold_class", 32'(bus.result_class), e_cls);
            check("hold_sum", 32'(bus.sum), e_sum);
        end
        start = 1'b1;
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.result_ready = 1'b0;
        check("valid_drop", 32'(bus.result_valid), 0);
        check("idle_after_done", 32'(busy), 0);
        @(posedge clk); #1;
        check("done_start_ignored", 32'(busy), 0);
        bus.pix_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_pix_req"}, 32'(bus.pix_req), 0);
        check({tag, "_pix_row"}, 32'(bus.pix_row), 0);
        check({tag, "_pix_col"}, 32'(bus.pix_col), 0);
        check({tag, "_valid"}, 32'(bus.result_valid), 0);
        check({tag, "_class"}, 32'(bus.result_class), 0);
        check({tag, "_sum"}, 32'(bus.sum), 0);
        check({tag, "_sum_left"}, 32'(bus.sum_left), 0);
        check({tag, "_lm_col"}, 32'(bus.leftmost_col), 0);
        check({tag, "_lm_found"}, 32'(bus.leftmost_found), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.result_ready = 1'b0;
        for (int r = 0; r < L; r++)
            for (int c = 0; c < W; c++) fb[r][c] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        fill(0); run_frame(1'b0, 1'b0, 0);
        fill(1); run_frame(1'b0, 1'b0, 0);
        fill(2); run_frame(1'b0, 1'b1, 2);
        fill(3); run_frame(1'b0, 1'b0, 1);
        fill(0); run_frame(1'b1, 1'b0, 0);
        fill(1); run_frame(1'b1, 1'b0, 0);
        fill(2); run_frame(1'b1, 1'b1, 0);

        fill(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.pix_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_sum", 32'(bus.sum), 5);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("mid_reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", 32'(busy), 0);
        check("post_reset_sum", 32'(bus.sum), 0);
        bus.pix_valid = 1'b0;

        fill(2); run_frame(1'b0, 1'b0, 10);

        for (int f = 0; f < 24; f++) begin
            fill($urandom_range(0, 5));
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
